// File: rtl/fp_add_requester.sv
// Request-side front end for the FloatAdder: queues tagged add requests and returns tagged results.
// Optional FP_REQ_ACCUM_EN adds ReqAccum and a running accumulator that can replace operand A.
module fp_add_requester #(
   parameter int ReqDepth      = 4,
   parameter int TagWidth      = 4,
   parameter int TimeoutCycles = 16
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                ReqValid,
   output logic                ReqReady,
   input  logic [31:0]         ReqOpA,
   input  logic [31:0]         ReqOpB,
   input  logic [TagWidth-1:0] ReqTag,
`ifdef FP_REQ_ACCUM_EN
   input  logic                ReqAccum,
`endif
   output logic [31:0]         AddOp1,
   output logic [31:0]         AddOp2,
   output logic                AddInputValid,
   input  logic [31:0]         AddResult,
   input  logic                AddResultValid,
   output logic                RspValid,
   input  logic                RspReady,
   output logic [31:0]         RspResult,
   output logic [TagWidth-1:0] RspTag,
   output logic                RspTimeout,
   output logic                Busy
);

   localparam int AW = $clog2(ReqDepth);
   localparam int CW = $clog2(TimeoutCycles) + 1;
   localparam logic [AW:0] Full = (AW+1)'(ReqDepth);
   // Counter lags the cycle count by one, so the last WAIT cycle sees TimeoutCycles-2.
   localparam logic [CW-1:0] TLast = CW'(TimeoutCycles - 2);
   localparam logic [31:0] QNaN = 32'h7FC00000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t state_q, state_d;

   logic [31:0]         fifo_a   [ReqDepth];
   logic [31:0]         fifo_b   [ReqDepth];
   logic [TagWidth-1:0] fifo_tag [ReqDepth];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         count;
   logic                push, pop;

   logic [31:0]         op_a, op_b;
   logic [TagWidth-1:0] tag_q;
   logic [CW-1:0]       cnt_q;
   logic [31:0]         rsp_result_q;
   logic                rsp_timeout_q;
   logic                stray_q;
   logic                res_hit, tmo_hit;

`ifdef FP_REQ_ACCUM_EN
   logic                fifo_acc [ReqDepth];
   logic                acc_sel_q;
   logic [31:0]         accum_q;
`endif

   assign ReqReady = (count != Full);
   assign push     = ReqValid && ReqReady;
   assign pop      = (state_q == IDLE) && (count != '0);

   assign res_hit = (state_q == WAIT) && AddResultValid;
   assign tmo_hit = (state_q == WAIT) && !AddResultValid
                    && (cnt_q == TLast);

   always_ff @(posedge Clock) begin
      if (push) begin
         fifo_a[wr_ptr]   <= ReqOpA;
         fifo_b[wr_ptr]   <= ReqOpB;
         fifo_tag[wr_ptr] <= ReqTag;
`ifdef FP_REQ_ACCUM_EN
         fifo_acc[wr_ptr] <= ReqAccum;
`endif
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         op_a  <= '0;
         op_b  <= '0;
         tag_q <= '0;
      end else if (pop) begin
         op_a  <= fifo_a[rd_ptr];
         op_b  <= fifo_b[rd_ptr];
         tag_q <= fifo_tag[rd_ptr];
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt_q <= '0;
      end else if (state_q == ISSUE) begin
         cnt_q <= '0;
      end else if (state_q == WAIT) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         rsp_result_q  <= '0;
         rsp_timeout_q <= 1'b0;
      end else if (res_hit) begin
         rsp_result_q  <= AddResult;
         rsp_timeout_q <= 1'b0;
      end else if (tmo_hit) begin
         rsp_result_q  <= QNaN;
         rsp_timeout_q <= 1'b1;
      end
   end

   // Sticky debug flag for results arriving outside WAIT.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         stray_q <= 1'b0;
      end else begin
         stray_q <= stray_q
                    | (AddResultValid && (state_q != WAIT));
      end
   end

`ifdef FP_REQ_ACCUM_EN
   always_ff @(posedge Clock) begin
      if (Reset) begin
         acc_sel_q <= 1'b0;
         accum_q   <= '0;
      end else begin
         if (pop)     acc_sel_q <= fifo_acc[rd_ptr];
         if (res_hit) accum_q   <= AddResult;
      end
   end

   assign AddOp1 = acc_sel_q ? accum_q : op_a;
`else
   assign AddOp1 = op_a;
`endif

   assign AddOp2     = op_b;
   assign RspResult  = rsp_result_q;
   assign RspTag     = tag_q;
   assign RspTimeout = rsp_timeout_q;
   assign Busy       = (state_q != IDLE) || (count != '0);

   always_ff @(posedge Clock) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (count != '0) state_d = ISSUE;
         ISSUE: state_d = WAIT;
         WAIT:  if (res_hit || tmo_hit) state_d = RESP;
         RESP:  if (RspReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      AddInputValid = 1'b0;
      RspValid      = 1'b0;
      unique case (state_q)
         IDLE:  ;
         ISSUE: AddInputValid = 1'b1;
         WAIT:  ;
         RESP:  RspValid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fp_add_requester.sv
// Directed bench for fp_add_requester with a behavioural adder and a response scoreboard.
// Define FP_REQ_ACCUM_EN at compile time to also cover the accumulator path.
module tb_fp_add_requester;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic [31:0] ReqOpA = '0;
   logic [31:0] ReqOpB = '0;
   logic [3:0]  ReqTag = '0;
   logic        req_acc = 1'b0;
   logic [31:0] AddOp1, AddOp2;
   logic        AddInputValid;
   logic [31:0] AddResult;
   logic        AddResultValid;
   logic        RspValid;
   logic        RspReady = 1'b1;
   logic [31:0] RspResult;
   logic [3:0]  RspTag;
   logic        RspTimeout;
   logic        Busy;

   fp_add_requester #(
      .ReqDepth(4),
      .TagWidth(4),
      .TimeoutCycles(16)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .ReqValid(ReqValid),
      .ReqReady(ReqReady),
      .ReqOpA(ReqOpA),
      .ReqOpB(ReqOpB),
      .ReqTag(ReqTag),
`ifdef FP_REQ_ACCUM_EN
      .ReqAccum(req_acc),
`endif
      .AddOp1(AddOp1),
      .AddOp2(AddOp2),
      .AddInputValid(AddInputValid),
      .AddResult(AddResult),
      .AddResultValid(AddResultValid),
      .RspValid(RspValid),
      .RspReady(RspReady),
      .RspResult(RspResult),
      .RspTag(RspTag),
      .RspTimeout(RspTimeout),
      .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] res;
      logic        tmo;
   } exp_t;

   exp_t sb[$];
   int total  = 0;
   int passed = 0;
   int cyc    = 0;

   always @(posedge Clock) cyc <= cyc + 1;

   // Known float sums; anything else uses a plain integer sum as a stand-in.
   function automatic logic [31:0] fadd(input logic [31:0] a,
                                        input logic [31:0] b);
      logic [63:0] k;
      k = {a, b};
      case (k)
         64'h00000000_3F800000: return 32'h3F800000;
         64'h3F800000_3F800000: return 32'h40000000;
         64'h40000000_3F800000: return 32'h40400000;
         64'h3F800000_40000000: return 32'h40400000;
         default:               return a + b;
      endcase
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
   endtask

   // Adder model: result valid add_lat cycles after InputValid; <=0 means never.
   int          add_lat   = 5;
   logic        model_rv  = 1'b0;
   logic        manual_rv = 1'b0;
   logic [31:0] model_res = '0;
   bit          pend = 0;
   int          cd = 0;
   logic [31:0] pa = '0;
   logic [31:0] pb = '0;

   assign AddResultValid = model_rv | manual_rv;
   assign AddResult      = model_res;

   always @(posedge Clock) begin
      model_rv <= 1'b0;
      if (pend) begin
         cd--;
         if (cd <= 0) begin
            model_rv  <= 1'b1;
            model_res <= fadd(pa, pb);
            pend = 0;
         end
      end
      if (AddInputValid === 1'b1 && add_lat > 0) begin
         pend = 1;
         cd   = add_lat - 1;
         pa   = AddOp1;
         pb   = AddOp2;
      end
   end

   int issue_cnt  = 0;
   int last_issue = -1;
   int rsp_cycles = 0;
   int last_acc   = -1;

   always @(negedge Clock) begin
      if (AddInputValid === 1'b1) begin
         issue_cnt++;
         last_issue = cyc;
      end
   end

   always @(negedge Clock) begin
      exp_t e;
      if (RspValid === 1'b1) rsp_cycles++;
      if (RspValid === 1'b1 && RspReady) begin
         last_acc = cyc;
         total++;
         assert (sb.size() != 0) passed++;
         else $error("FAIL rsp_unexpected tag=%0h observed=extra expected=none",
                     RspTag);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_tag", 32'(RspTag), 32'(e.tag));
            chk("rsp_result", RspResult, e.res);
            chk("rsp_timeout", 32'(RspTimeout), 32'(e.tmo));
         end
      end
   end

   task automatic push(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [3:0]  tag,
                       input logic        acc,
                       input logic [31:0] er,
                       input logic        et,
                       output int         pc);
      bit got = 0;
      pc      = -1;
      ReqValid = 1'b1;
      ReqOpA   = a;
      ReqOpB   = b;
      ReqTag   = tag;
      req_acc  = acc;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge Clock);
         if (ReqReady) begin
            got = 1;
            pc  = cyc;
            sb.push_back('{tag, er, et});
         end
         @(posedge Clock);
         #1;
      end
      ReqValid = 1'b0;
      chk("push_accept", 32'(got), 32'd1);
   endtask

   task automatic wait_rsp(output int rc);
      bit got = 0;
      rc = -1;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge Clock);
         if (RspValid === 1'b1) begin
            got = 1;
            rc  = cyc;
         end
      end
      chk("rsp_arrives", 32'(got), 32'd1);
   endtask

   task automatic drain();
      bit got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge Clock);
         if (sb.size() == 0 && Busy === 1'b0) got = 1;
      end
      chk("drain", 32'(got), 32'd1);
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_issue(input int n0);
      bit got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge Clock);
         if (issue_cnt != n0) got = 1;
      end
      chk("issue_seen", 32'(got), 32'd1);
   endtask

   initial begin
      int pc, rc, n0, r0;
      logic [31:0] h_res;
      logic [3:0]  h_tag;

      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(negedge Clock);
      chk("rst_req_ready", 32'(ReqReady), 32'd1);
      chk("rst_rsp_valid", 32'(RspValid), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_in_valid", 32'(AddInputValid), 32'd0);
      chk("rst_result", RspResult, 32'd0);
      chk("rst_timeout", 32'(RspTimeout), 32'd0);
      @(posedge Clock);
      #1;

      // Single operation with a 5-cycle adder.
      add_lat = 5;
      n0 = issue_cnt;
      push(32'h3F800000, 32'h40000000, 4'd3, 1'b0,
           32'h40400000, 1'b0, pc);
      wait_rsp(rc);
      chk("push_to_issue", 32'(last_issue - pc), 32'd2);
      chk("issue_to_rsp", 32'(rc - last_issue), 32'd6);
      drain();
      chk("single_pulse", 32'(issue_cnt - n0), 32'd1);

      // Five back-to-back pushes into a depth-4 FIFO.
      add_lat = 3;
      n0 = issue_cnt;
      for (int i = 0; i < 5; i++) begin
         logic [31:0] a, b;
         a = 32'h10 + 32'(i);
         b = 32'h100 * 32'(i);
         push(a, b, 4'(i), 1'b0, a + b, 1'b0, pc);
      end
      @(negedge Clock);
      chk("full_ready", 32'(ReqReady), 32'd0);
      chk("full_busy", 32'(Busy), 32'd1);
      @(posedge Clock);
      #1;
      drain();
      chk("five_issues", 32'(issue_cnt - n0), 32'd5);

      // Adder never answers: timeout response, then normal service.
      add_lat = -1;
      push(32'h1, 32'h2, 4'd7, 1'b0, 32'h7FC00000, 1'b1, pc);
      wait_rsp(rc);
      chk("timeout_delay", 32'(rc - last_issue), 32'd16);
      drain();
      add_lat = 4;
      push(32'h3F800000, 32'h3F800000, 4'd8, 1'b0,
           32'h40000000, 1'b0, pc);
      wait_rsp(rc);
      chk("after_tmo_delay", 32'(rc - last_issue), 32'd5);
      drain();

      // Back-pressure in RESP with a second request queued.
      RspReady = 1'b0;
      add_lat  = 3;
      push(32'h40000000, 32'h3F800000, 4'd9, 1'b0,
           32'h40400000, 1'b0, pc);
      push(32'h21, 32'h43, 4'd10, 1'b0, 32'h64, 1'b0, pc);
      wait_rsp(rc);
      h_res = RspResult;
      h_tag = RspTag;
      n0    = issue_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         chk("hold_valid", 32'(RspValid), 32'd1);
         chk("hold_result", RspResult, h_res);
         chk("hold_tag", 32'(RspTag), 32'(h_tag));
      end
      chk("hold_no_issue", 32'(issue_cnt - n0), 32'd0);
      @(posedge Clock);
      #1;
      RspReady = 1'b1;
      wait_issue(n0);
      chk("accept_to_issue", 32'(last_issue - last_acc), 32'd2);
      drain();

      // Reset while waiting; a late result must be ignored.
      add_lat = -1;
      n0 = issue_cnt;
      push(32'h5, 32'h6, 4'd11, 1'b0, 32'h7FC00000, 1'b1, pc);
      wait_issue(n0);
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      sb.delete();
      manual_rv = 1'b1;
      @(posedge Clock);
      #1;
      manual_rv = 1'b0;
      r0 = rsp_cycles;
      repeat (20) @(negedge Clock);
      chk("rst_no_rsp", 32'(rsp_cycles - r0), 32'd0);
      chk("rst_ready", 32'(ReqReady), 32'd1);
      chk("rst_idle", 32'(Busy), 32'd0);
      @(posedge Clock);
      #1;

`ifdef FP_REQ_ACCUM_EN
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      add_lat = 3;
      push(32'h12345678, 32'h3F800000, 4'd1, 1'b1,
           32'h3F800000, 1'b0, pc);
      push(32'h12345678, 32'h3F800000, 4'd2, 1'b1,
           32'h40000000, 1'b0, pc);
      push(32'h12345678, 32'h3F800000, 4'd3, 1'b1,
           32'h40400000, 1'b0, pc);
      drain();
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
